text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_pkg.sv | 15 +
 rtl/sync_delay.sv | 31 +++
 rtl/text_renderer.sv | 188 ++++++++++++++++++
 tb/tb_text_renderer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the text-mode renderer.
// Holds the screen geometry defaults, cell attribute layout and pipeline depth.
package text_pkg;

    localparam int DEF_COLS     = 80;
    localparam int DEF_ROWS     = 30;
    localparam int PIPE_LATENCY = 4;

    // Text buffer cell layout: {bg, fg, char}
    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;
    localparam int ATTR_W   = 4;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that keeps de/hsync/vsync aligned with pixel data.
// Each bit resets to its own inactive level.
module sync_delay #(
    parameter int           DEPTH   = 4,
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= RST_VAL;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/text_renderer.sv
// Character-cell text renderer: pixel coordinate -> buffer cell -> glyph -> palette index.
// Four-stage pipeline around an external sync text buffer and registered font ROM.
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS             = DEF_COLS,
    parameter int ROWS             = DEF_ROWS,
    parameter int FONT_WIDTH       = 8,
    parameter int FONT_HEIGHT      = 16,
    parameter int BLINK_FRAMES     = 30,
    parameter int CURSOR_FIRST_ROW = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [9:0]                     pix_x,
    input  logic [9:0]                     pix_y,
    input  logic                           de_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    output logic [$clog2(COLS*ROWS)-1:0]   tbuf_addr,
    input  logic [15:0]                    tbuf_data,
    output logic [7:0]                     font_codepoint,
    output logic [$clog2(FONT_HEIGHT)-1:0] font_row,
    input  logic [FONT_WIDTH-1:0]          font_bitmap,
    input  logic                           cursor_en,
    input  logic [6:0]                     cursor_col,
    input  logic [4:0]                     cursor_row,
    output logic [3:0]                     color_out,
    output logic                           de_out,
    output logic                           hsync_out,
    output logic                           vsync_out
);

    localparam int AW    = $clog2(COLS*ROWS);
    localparam int FW_W  = $clog2(FONT_WIDTH);
    localparam int FH_W  = $clog2(FONT_HEIGHT);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]       X_MAX    = 10'(COLS*FONT_WIDTH);
    localparam logic [9:0]       Y_MAX    = 10'(ROWS*FONT_HEIGHT);
    localparam logic [AW-1:0]    COLS_A   = AW'(COLS);
    localparam logic [FH_W-1:0]  CUR_ROW0 = FH_W'(CURSOR_FIRST_ROW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES-1);

    // Blink phase state
    logic             vs_prev;
    logic [CNT_W-1:0] frame_cnt;
    logic             blink_on;

    // Stage 1: address issued to the text buffer
    logic [9:0]      cell_x;
    logic [9:0]      cell_y;
    logic            oob_c;
    logic            hit_c;
    logic [AW-1:0]   addr_c;
    logic            s1_de;
    logic            s1_oob;
    logic            s1_hit;
    logic [FW_W-1:0] s1_subx;
    logic [FH_W-1:0] s1_row;

    // Stage 2: buffer data valid, font lookup issued
    logic            s2_de;
    logic            s2_oob;
    logic            s2_hit;
    logic [FW_W-1:0] s2_subx;
    logic [FH_W-1:0] s2_row;

    // Stage 3: font bitmap valid
    logic              s3_de;
    logic              s3_oob;
    logic              s3_swap;
    logic [FW_W-1:0]   s3_subx;
    logic [ATTR_W-1:0] s3_fg;
    logic [ATTR_W-1:0] s3_bg;

    logic              pix_bit;
    logic [ATTR_W-1:0] fg_eff;
    logic [ATTR_W-1:0] bg_eff;
    logic [2:0]        dly_q;

    always_comb begin
        cell_x = pix_x >> FW_W;
        cell_y = pix_y >> FH_W;
        oob_c  = (pix_x >= X_MAX) || (pix_y >= Y_MAX);
        addr_c = '0;
        if (!oob_c) begin
            addr_c = AW'(cell_y) * COLS_A + AW'(cell_x);
        end
        hit_c = cursor_en && blink_on &&
                (cell_x == 10'(cursor_col)) &&
                (cell_y == 10'(cursor_row));
    end

    // Blink phase advances on each vsync falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev   <= 1'b1;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (vs_prev && !vsync_in) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbuf_addr <= '0;
            s1_de     <= 1'b0;
            s1_oob    <= 1'b0;
            s1_hit    <= 1'b0;
            s1_subx   <= '0;
            s1_row    <= '0;
            s2_de     <= 1'b0;
            s2_oob    <= 1'b0;
            s2_hit    <= 1'b0;
            s2_subx   <= '0;
            s2_row    <= '0;
            s3_de     <= 1'b0;
            s3_oob    <= 1'b0;
            s3_swap   <= 1'b0;
            s3_subx   <= '0;
            s3_fg     <= '0;
            s3_bg     <= '0;
            color_out <= '0;
        end else begin
            tbuf_addr <= addr_c;
            s1_de     <= de_in;
            s1_oob    <= oob_c;
            s1_hit    <= hit_c;
            s1_subx   <= pix_x[FW_W-1:0];
            s1_row    <= pix_y[FH_W-1:0];

            s2_de     <= s1_de;
            s2_oob    <= s1_oob;
            s2_hit    <= s1_hit;
            s2_subx   <= s1_subx;
            s2_row    <= s1_row;

            s3_de     <= s2_de;
            s3_oob    <= s2_oob;
            s3_swap   <= s2_hit && (s2_row >= CUR_ROW0);
            s3_subx   <= s2_subx;
            s3_fg     <= tbuf_data[FG_LSB +: ATTR_W];
            s3_bg     <= tbuf_data[BG_LSB +: ATTR_W];

            if (!s3_de || s3_oob) begin
                color_out <= '0;
            end else begin
                color_out <= pix_bit ? fg_eff : bg_eff;
            end
        end
    end

    assign font_codepoint = tbuf_data[CHAR_LSB +: 8];
    assign font_row       = s2_row;

    // Leftmost pixel is the MSB, so the bit index is the inverted sub-x
    always_comb begin
        pix_bit = font_bitmap[~s3_subx];
        fg_eff  = s3_swap ? s3_bg : s3_fg;
        bg_eff  = s3_swap ? s3_fg : s3_bg;
    end

    sync_delay #(
        .DEPTH   (PIPE_LATENCY),
        .W       (3),
        .RST_VAL (3'b011)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({de_in, hsync_in, vsync_in}),
        .q     (dly_q)
    );

    assign de_out    = dly_q[2];
    assign hsync_out = dly_q[1];
    assign vsync_out = dly_q[0];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer with behavioural text buffer and font ROM.
// Table vectors and corner-case sequences feed a fixed-latency scoreboard.
module tb_text_renderer;
    import text_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] tbuf_addr;
    logic [15:0] tbuf_data = '0;
    logic [7:0]  font_codepoint;
    logic [3:0]  font_row;
    logic [7:0]  font_bitmap = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [3:0]  color_out;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    logic [15:0] tbuf_mem [0:4095];
    logic [7:0]  font_mem [0:4095];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       cen;
        logic [6:0] ccol;
        logic [4:0] crow;
        logic [3:0] col;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] col;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   vid = 0;

    text_renderer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .de_in          (de_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .tbuf_addr      (tbuf_addr),
        .tbuf_data      (tbuf_data),
        .font_codepoint (font_codepoint),
        .font_row       (font_row),
        .font_bitmap    (font_bitmap),
        .cursor_en      (cursor_en),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .color_out      (color_out),
        .de_out         (de_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out)
    );

    always #5 clk = ~clk;

    // Synchronous text buffer and registered font ROM
    always @(posedge clk) begin
        tbuf_data   <= tbuf_mem[tbuf_addr];
        font_bitmap <= font_mem[{font_codepoint, font_row}];
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x, input int y, input logic de,
                                input logic hs, input logic vs,
                                input logic cen, input int ccol,
                                input int crow, input int col);
        vec_t v;
        v.x    = 10'(x);
        v.y    = 10'(y);
        v.de   = de;
        v.hs   = hs;
        v.vs   = vs;
        v.cen  = cen;
        v.ccol = 7'(ccol);
        v.crow = 5'(crow);
        v.col  = 4'(col);
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        if (sbq.size() == PIPE_LATENCY) begin
            e = sbq.pop_front();
            check($sformatf("color#%0d", e.id), 16'(color_out), 16'(e.col));
            check($sformatf("de#%0d", e.id), 16'(de_out), 16'(e.de));
            check($sformatf("hs#%0d", e.id), 16'(hsync_out), 16'(e.hs));
            check($sformatf("vs#%0d", e.id), 16'(vsync_out), 16'(e.vs));
        end
        pix_x      = v.x;
        pix_y      = v.y;
        de_in      = v.de;
        hsync_in   = v.hs;
        vsync_in   = v.vs;
        cursor_en  = v.cen;
        cursor_col = v.ccol;
        cursor_row = v.crow;
        e.id  = vid;
        e.col = v.col;
        e.de  = v.de;
        e.hs  = v.hs;
        e.vs  = v.vs;
        vid++;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n, input logic vs);
        for (int i = 0; i < n; i++) begin
            step(mk(0, 0, 1'b0, 1'b1, vs, 1'b0, 0, 0, 0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cursor_en = 1'b0;
        #1;
        check("rst_color", 16'(color_out), 16'h0);
        check("rst_de", 16'(de_out), 16'h0);
        check("rst_hs", 16'(hsync_out), 16'h1);
        check("rst_vs", 16'(vsync_out), 16'h1);
        check("rst_addr", 16'(tbuf_addr), 16'h0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tbuf_mem[i] = '0;
            font_mem[i] = '0;
        end
        tbuf_mem[0]  = 16'h1F41;
        tbuf_mem[1]  = 16'h2E42;
        tbuf_mem[79] = 16'h3C41;
        tbuf_mem[81] = 16'h0055;
        tbuf_mem[82] = 16'h0700;
        tbuf_mem[83] = 16'h0700;
        font_mem[{8'h41, 4'd0}] = 8'h18;
        for (int r = 0; r < 16; r++) begin
            font_mem[{8'h42, 4'(r)}] = 8'hFF;
        end

        // Glyph, attribute, de gating and bounds vectors
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(2, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(3, 0, 1, 1, 1, 0, 0, 0, 15));
        tbl.push_back(mk(4, 0, 1, 1, 1, 0, 0, 0, 15));
        tbl.push_back(mk(5, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(6, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(7, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(8, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(9, 0, 1, 1, 1, 0, 0, 0, 14));
        tbl.push_back(mk(10, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(11, 0, 1, 0, 0, 0, 0, 0, 14));
        tbl.push_back(mk(12, 0, 1, 1, 0, 0, 0, 0, 14));
        tbl.push_back(mk(13, 5, 1, 1, 1, 0, 0, 0, 14));
        tbl.push_back(mk(15, 15, 1, 1, 1, 0, 0, 0, 14));
        tbl.push_back(mk(639, 0, 1, 1, 1, 0, 0, 0, 3));
        tbl.push_back(mk(640, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 480, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Address and font-row timing probes
        step(mk(8, 16, 1, 1, 1, 0, 0, 0, 0));
        step(mk(8, 31, 1, 1, 1, 0, 0, 0, 0));
        check("addr_8_16", 16'(tbuf_addr), 16'd81);
        step(mk(9, 0, 1, 1, 1, 0, 0, 0, 14));
        check("frow_y16", 16'(font_row), 16'd0);
        check("codepoint", 16'(font_codepoint), 16'h55);
        check("addr_8_31", 16'(tbuf_addr), 16'd81);
        step(mk(640, 0, 1, 1, 1, 0, 0, 0, 0));
        check("frow_y31", 16'(font_row), 16'd15);
        check("addr_9_0", 16'(tbuf_addr), 16'd1);
        idle(1, 1'b1);
        check("addr_clamp", 16'(tbuf_addr), 16'd0);
        idle(4, 1'b1);

        // Underline cursor at (2,1), mid-line moves and blink
        do_reset();
        step(mk(16, 16, 1, 1, 1, 1, 2, 1, 0));
        step(mk(17, 29, 1, 1, 1, 1, 2, 1, 0));
        step(mk(18, 30, 1, 1, 1, 1, 2, 1, 7));
        step(mk(23, 31, 1, 1, 1, 1, 2, 1, 7));
        step(mk(24, 31, 1, 1, 1, 1, 2, 1, 0));
        step(mk(24, 31, 1, 1, 1, 1, 3, 1, 7));
        step(mk(23, 31, 1, 1, 1, 1, 3, 1, 0));
        step(mk(16, 31, 1, 1, 1, 0, 2, 1, 0));
        for (int i = 0; i < 29; i++) begin
            idle(1, 1'b0);
            idle(1, 1'b1);
        end
        step(mk(18, 30, 1, 1, 1, 1, 2, 1, 7));
        idle(1, 1'b0);
        idle(1, 1'b1);
        step(mk(18, 30, 1, 1, 1, 1, 2, 1, 0));
        step(mk(23, 31, 1, 1, 1, 1, 2, 1, 0));
        step(mk(17, 16, 1, 1, 1, 1, 2, 1, 0));

        // Reset mid-line, then restart with no stale pixels
        for (int i = 8; i < 14; i++) begin
            step(mk(i, 0, 1, 1, 1, 0, 0, 0, 14));
        end
        do_reset();
        idle(3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i]);
        end
        idle(5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
